deinterleaver_top: RTL and testbench



---
 rtl/deinterleaver_top.sv | 102 ++++++++++
 tb/tb_deinterleaver_top.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver_top.sv
// WiMAX 802.16 receive block-deinterleaver (QPSK, Ncbps = 192, d = 16) with
// ping-pong bit banks for continuous 1 bit/cycle streaming under valid/ready.
module deinterleaver_top (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  input  logic ready_in,
  output logic data_out,
  output logic valid_out
);

  localparam int NCBPS = 192;
  localparam logic [3:0] ROW_LAST = 4'd11;
  localparam logic [3:0] COL_LAST = 4'd15;
  localparam logic [7:0] ADDR_LAST = 8'(NCBPS - 1);

  logic [NCBPS-1:0] bank [2];
  logic [1:0] full;
  logic [1:0] full_nx;
  logic       wr_sel;
  logic       rd_sel;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] rd_addr;
  logic [7:0] wr_addr;
  logic       in_fire;
  logic       blk_done;
  logic       load;
  logic       last_load;

  assign ready_out = !full[wr_sel];
  assign in_fire   = valid_in && ready_out;
  // Row-major placement of column-ordered input: k = 16*(j mod 12) + j/12.
  assign wr_addr   = {row, col};
  assign blk_done  = in_fire && (row == ROW_LAST) && (col == COL_LAST);
  assign load      = full[rd_sel] && (!valid_out || ready_in);
  assign last_load = load && (rd_addr == ADDR_LAST);

  // A set and a clear on the same edge always target different banks.
  always_comb begin
    full_nx = full;
    if (blk_done)  full_nx[wr_sel] = 1'b1;
    if (last_load) full_nx[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      full <= full_nx;
    end
  end

  // Write side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row    <= '0;
      col    <= '0;
      wr_sel <= 1'b0;
    end else if (in_fire) begin
      if (row == ROW_LAST) begin
        row <= '0;
        if (col == COL_LAST) begin
          col    <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          col <= col + 4'd1;
        end
      end else begin
        row <= row + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) bank[wr_sel][wr_addr] <= data_in;
  end

  // Read side: sequential drain into a single output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr   <= '0;
      rd_sel    <= 1'b0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= bank[rd_sel][rd_addr];
      valid_out <= 1'b1;
      if (last_load) begin
        rd_addr <= '0;
        rd_sel  <= ~rd_sel;
      end else begin
        rd_addr <= rd_addr + 8'd1;
      end
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deinterleaver_top.sv
// Directed/randomized bench for deinterleaver_top against a block-level
// reference: out[n] = in[12*(n mod 16) + n/16] within each 192-bit block.
module tb_deinterleaver_top;

  logic clk;
  logic reset;
  logic data_in;
  logic valid_in;
  logic ready_out;
  logic ready_in;
  logic data_out;
  logic valid_out;

  deinterleaver_top dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit cur_blk [192];
  int cur_n = 0;
  bit exp_q [$];
  bit got [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_push(input bit b);
    cur_blk[cur_n] = b;
    cur_n++;
    if (cur_n == 192) begin
      for (int n = 0; n < 192; n++) exp_q.push_back(cur_blk[12 * (n % 16) + n / 16]);
      cur_n = 0;
    end
  endtask

  task automatic model_clear();
    cur_n = 0;
    exp_q.delete();
    got.delete();
  endtask

  // One clock: observe transfers on the pre-edge values, then advance.
  task automatic step();
    bit inf;
    bit outf;
    bit e;
    inf  = valid_in && ready_out;
    outf = valid_out && ready_in;
    if (outf) begin
      got.push_back(data_out);
      check("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(data_out), 32'(e));
      end
    end
    if (inf) model_push(data_in);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input bit [191:0] blk, input bit rin, input string tag);
    int idx;
    int budget;
    idx = 0;
    budget = 1000;
    while (idx < 192 && budget > 0) begin
      valid_in = 1'b1;
      data_in  = blk[idx];
      ready_in = rin;
      if (ready_out) idx++;
      step();
      budget--;
    end
    valid_in = 1'b0;
    check({tag, "_accepted"}, idx, 192);
  endtask

  task automatic drain(input bit rand_rdy, input string tag);
    int budget;
    budget = 3000;
    valid_in = 1'b0;
    while ((exp_q.size() != 0 || valid_out) && budget > 0) begin
      ready_in = rand_rdy ? (($urandom % 10) < 7) : 1'b1;
      step();
      budget--;
    end
    ready_in = 1'b1;
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_single(input int j, input int n_exp, input string tag);
    int pos;
    int ones;
    got.delete();
    feed(192'(1) << j, 1'b1, tag);
    drain(1'b0, tag);
    pos = -1;
    ones = 0;
    foreach (got[i]) if (got[i]) begin pos = i; ones++; end
    check({tag, "_count"}, got.size(), 192);
    check({tag, "_ones"}, ones, 1);
    check({tag, "_pos"}, pos, n_exp);
  endtask

  task automatic async_reset(input string tag);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    check({tag, "_valid_out"}, 32'(valid_out), 0);
    check({tag, "_ready_out"}, 32'(ready_out), 1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_held"}, 32'(ready_out), 1);
    check({tag, "_data_out"}, 32'(data_out), 0);
    reset = 1'b0;
    model_clear();
  endtask

  bit [191:0] blk;
  bit [191:0] orig [3];
  bit [191:0] tx [3];
  int drops;
  int bubbles;
  int errs;
  int acc;
  int budget;
  logic d0;

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;
    ready_in = 1'b1;
    #1;
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_ready_out", 32'(ready_out), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Mapping
    run_single(12, 1, "map_j12");
    run_single(1, 16, "map_j1");
    run_single(191, 191, "map_j191");

    // Streaming: 4 back-to-back blocks
    got.delete();
    drops = 0;
    bubbles = 0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 192; j++) begin
        valid_in = 1'b1;
        ready_in = 1'b1;
        data_in  = 1'($urandom);
        if (b >= 1 && !ready_out) drops++;
        if (b == 1 && j == 0) check("lat_not_yet", 32'(valid_out), 0);
        if (b == 1 && j == 1) check("lat_first", 32'(valid_out), 1);
        if (b >= 1 && !(b == 1 && j == 0) && !valid_out) bubbles++;
        step();
      end
    end
    drain(1'b0, "stream");
    check("stream_count", got.size(), 768);
    check("stream_ready_drops", drops, 0);
    check("stream_bubbles", bubbles, 0);

    // Round trip through a transmit interleaver model
    got.delete();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 192; k++) orig[b][k] = 1'($urandom);
      for (int k = 0; k < 192; k++) tx[b][12 * (k % 16) + k / 16] = orig[b][k];
    end
    for (int b = 0; b < 3; b++) feed(tx[b], 1'b1, "rt_feed");
    drain(1'b0, "rt");
    check("rt_count", got.size(), 576);
    errs = 0;
    foreach (got[i]) if (i < 576 && got[i] != orig[i / 192][i % 192]) errs++;
    check("rt_mismatches", errs, 0);

    // Backpressure
    got.delete();
    for (int k = 0; k < 192; k++) blk[k] = 1'($urandom);
    feed(blk, 1'b0, "bp_blk1");
    for (int k = 0; k < 192; k++) blk[k] = 1'($urandom);
    feed(blk, 1'b0, "bp_blk2");
    check("bp_ready_low", 32'(ready_out), 0);
    check("bp_valid_held", 32'(valid_out), 1);
    d0 = data_out;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1;
      ready_in = 1'b0;
      data_in  = 1'($urandom);
      step();
      if (ready_out !== 1'b0 || valid_out !== 1'b1 || data_out !== d0) errs++;
    end
    valid_in = 1'b0;
    check("bp_stall_stable", errs, 0);
    drain(1'b0, "bp");
    check("bp_count", got.size(), 384);

    // Gapped input with random backpressure
    got.delete();
    acc = 0;
    budget = 8000;
    while (acc < 576 && budget > 0) begin
      valid_in = 1'($urandom % 2);
      data_in  = 1'($urandom);
      ready_in = (($urandom % 10) < 7);
      if (valid_in && ready_out) acc++;
      step();
      budget--;
    end
    valid_in = 1'b0;
    check("gap_accepted", acc, 576);
    drain(1'b1, "gap");
    check("gap_count", got.size(), 576);

    // Reset mid-block, then a fresh block
    for (int i = 0; i < 100; i++) begin
      valid_in = 1'b1;
      ready_in = 1'b1;
      data_in  = 1'($urandom);
      step();
    end
    async_reset("rst_mid_block");
    run_single(12, 1, "post_rst1");

    // Reset mid-drain, then a fresh block
    for (int k = 0; k < 192; k++) blk[k] = 1'($urandom);
    feed(blk, 1'b1, "rd_blk");
    for (int i = 0; i < 50; i++) begin
      ready_in = 1'b1;
      step();
    end
    check("pre_rst_valid", 32'(valid_out), 1);
    async_reset("rst_mid_drain");
    run_single(191, 191, "post_rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
